// File: rtl/pc_unit.sv
// pc_unit: fetch program counter with next-PC selection.
// Selects among exception entry, eret return, buffered redirect, jump, branch
// and sequential increment. A jump or branch that arrives while IF is stalled
// is held in a one-entry pending buffer and applied on the first enabled cycle.
module pc_unit #(
    parameter int                 WIDTH     = 32,
    parameter logic [WIDTH-1:0]   RESET_VEC = 32'h00003000,
    parameter logic [WIDTH-1:0]   EXC_VEC   = 32'h00004180,
    parameter int                 INC       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             br_take,
    input  logic [WIDTH-1:0] br_target,
    input  logic             jmp_take,
    input  logic [WIDTH-1:0] jmp_target,
    input  logic             exc_req,
    input  logic             eret_req,
    input  logic [WIDTH-1:0] epc_in,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus,
    output logic             redirect_pend,
    output logic             misalign
);

    // Pending-buffer entry kind; JMP outranks BR when both are stalled.
    localparam logic KIND_BR  = 1'b0;
    localparam logic KIND_JMP = 1'b1;

    localparam logic [WIDTH-1:0] INC_V = WIDTH'(INC);

    logic [WIDTH-1:0] pc_r;
    logic             pend_valid_r;
    logic             pend_kind_r;
    logic [WIDTH-1:0] pend_target_r;

    logic [WIDTH-1:0] pc_plus_s;
    logic [WIDTH-1:0] pc_next_s;
    logic             pend_valid_next_s;
    logic             pend_kind_next_s;
    logic [WIDTH-1:0] pend_target_next_s;

    // Sequential successor; wraps modulo 2^WIDTH with no overflow indication.
    always_comb begin
        pc_plus_s = pc_r + INC_V;
    end

    // Next-PC selection and pending-buffer update in priority order.
    always_comb begin
        pc_next_s          = pc_r;
        pend_valid_next_s  = pend_valid_r;
        pend_kind_next_s   = pend_kind_r;
        pend_target_next_s = pend_target_r;

        if (exc_req) begin
            pc_next_s         = EXC_VEC;
            pend_valid_next_s = 1'b0;
        end else if (eret_req) begin
            pc_next_s         = epc_in;
            pend_valid_next_s = 1'b0;
        end else if (en) begin
            // The stalled instruction's redirect wins over any fresh request.
            if (pend_valid_r) begin
                pc_next_s         = pend_target_r;
                pend_valid_next_s = 1'b0;
            end else if (jmp_take) begin
                pc_next_s = jmp_target;
            end else if (br_take) begin
                pc_next_s = br_target;
            end else begin
                pc_next_s = pc_plus_s;
            end
        end else begin
            // Stalled: capture a redirect, replacing a buffered one only when
            // the new request strictly outranks it.
            if (jmp_take) begin
                if (!pend_valid_r || (pend_kind_r == KIND_BR)) begin
                    pend_valid_next_s  = 1'b1;
                    pend_kind_next_s   = KIND_JMP;
                    pend_target_next_s = jmp_target;
                end else begin
                    pend_valid_next_s  = pend_valid_r;
                end
            end else if (br_take) begin
                if (!pend_valid_r) begin
                    pend_valid_next_s  = 1'b1;
                    pend_kind_next_s   = KIND_BR;
                    pend_target_next_s = br_target;
                end else begin
                    pend_valid_next_s  = pend_valid_r;
                end
            end else begin
                pend_valid_next_s = pend_valid_r;
            end
        end
    end

    // PC and pending-buffer state; synchronous reset discards any pending entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r          <= RESET_VEC;
            pend_valid_r  <= 1'b0;
            pend_kind_r   <= KIND_BR;
            pend_target_r <= {WIDTH{1'b0}};
        end else begin
            pc_r          <= pc_next_s;
            pend_valid_r  <= pend_valid_next_s;
            pend_kind_r   <= pend_kind_next_s;
            pend_target_r <= pend_target_next_s;
        end
    end

    // Output mapping; misalign is a plain decode of the low address bits.
    always_comb begin
        pc            = pc_r;
        pc_plus       = pc_plus_s;
        redirect_pend = pend_valid_r;
        misalign      = (pc_r[1:0] != 2'b00);
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit.
module tb_pc_unit;

    logic        clk;
    logic        reset;
    logic        en;
    logic        br_take;
    logic [31:0] br_target;
    logic        jmp_take;
    logic [31:0] jmp_target;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc_in;
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic        redirect_pend;
    logic        misalign;

    int pass_cnt;
    int total_cnt;

    pc_unit dut (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .br_take       (br_take),
        .br_target     (br_target),
        .jmp_take      (jmp_take),
        .jmp_target    (jmp_target),
        .exc_req       (exc_req),
        .eret_req      (eret_req),
        .epc_in        (epc_in),
        .pc            (pc),
        .pc_plus       (pc_plus),
        .redirect_pend (redirect_pend),
        .misalign      (misalign)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0;
        step();
        reset = 1'b0;
        total_cnt++; if (pc !== 32'h00003000) $display("FAIL reset_pc got %h exp %h", pc, 32'h00003000); else pass_cnt++;
        total_cnt++; if (redirect_pend !== 1'b0) $display("FAIL reset_pend got %b exp 0", redirect_pend); else pass_cnt++;
        total_cnt++; if (misalign !== 1'b0) $display("FAIL reset_misalign got %b exp 0", misalign); else pass_cnt++;
        total_cnt++; if (pc_plus !== 32'h00003004) $display("FAIL reset_pc_plus got %h exp %h", pc_plus, 32'h00003004); else pass_cnt++;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        exp_pc = 32'h00003000;
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            exp_pc = exp_pc + 32'd4;
            total_cnt++; if (pc !== exp_pc) $display("FAIL seq_pc[%0d] got %h exp %h", i, pc, exp_pc); else pass_cnt++;
        end
        total_cnt++; if (redirect_pend !== 1'b0) $display("FAIL seq_pend got %b exp 0", redirect_pend); else pass_cnt++;
    endtask

    // pc = 0x3010 on entry.
    task automatic test_buffered_branch();
        en = 1'b0; br_take = 1'b1; br_target = 32'h00003040;
        step();
        br_take = 1'b0;
        total_cnt++; if (pc !== 32'h00003010) $display("FAIL bufbr_hold0 got %h exp %h", pc, 32'h00003010); else pass_cnt++;
        total_cnt++; if (redirect_pend !== 1'b1) $display("FAIL bufbr_pend0 got %b exp 1", redirect_pend); else pass_cnt++;
        for (int i = 0; i < 2; i++) begin
            step();
            total_cnt++; if (pc !== 32'h00003010) $display("FAIL bufbr_hold[%0d] got %h exp %h", i, pc, 32'h00003010); else pass_cnt++;
            total_cnt++; if (redirect_pend !== 1'b1) $display("FAIL bufbr_pend[%0d] got %b exp 1", i, redirect_pend); else pass_cnt++;
        end
        en = 1'b1;
        step();
        total_cnt++; if (pc !== 32'h00003040) $display("FAIL bufbr_apply got %h exp %h", pc, 32'h00003040); else pass_cnt++;
        total_cnt++; if (redirect_pend !== 1'b0) $display("FAIL bufbr_clear got %b exp 0", redirect_pend); else pass_cnt++;
    endtask

    // pc = 0x3040 on entry.
    task automatic test_pending_priority();
        // BR buffered first, then JMP overrides it.
        en = 1'b0; br_take = 1'b1; br_target = 32'h00003040;
        step();
        br_take = 1'b0; jmp_take = 1'b1; jmp_target = 32'h00003100;
        step();
        jmp_take = 1'b0; en = 1'b1;
        step();
        total_cnt++; if (pc !== 32'h00003100) $display("FAIL prio_br_then_jmp got %h exp %h", pc, 32'h00003100); else pass_cnt++;
        step();
        total_cnt++; if (pc !== 32'h00003104) $display("FAIL prio_seq got %h exp %h", pc, 32'h00003104); else pass_cnt++;
        // JMP buffered first, later BR must not replace it.
        en = 1'b0; jmp_take = 1'b1; jmp_target = 32'h00003100;
        step();
        jmp_take = 1'b0; br_take = 1'b1; br_target = 32'h00003040;
        step();
        br_take = 1'b0; en = 1'b1;
        step();
        total_cnt++; if (pc !== 32'h00003100) $display("FAIL prio_jmp_then_br got %h exp %h", pc, 32'h00003100); else pass_cnt++;
        // Fresh jump on the release cycle is ignored in favour of the buffered BR.
        en = 1'b0; br_take = 1'b1; br_target = 32'h00003040;
        step();
        br_take = 1'b0; en = 1'b1; jmp_take = 1'b1; jmp_target = 32'h00003300;
        step();
        jmp_take = 1'b0;
        total_cnt++; if (pc !== 32'h00003040) $display("FAIL prio_fresh_ignored got %h exp %h", pc, 32'h00003040); else pass_cnt++;
        total_cnt++; if (redirect_pend !== 1'b0) $display("FAIL prio_fresh_pend got %b exp 0", redirect_pend); else pass_cnt++;
    endtask

    task automatic test_exc_eret();
        en = 1'b0; br_take = 1'b1; br_target = 32'h00003040;
        step();
        br_take = 1'b0;
        total_cnt++; if (redirect_pend !== 1'b1) $display("FAIL exc_pre_pend got %b exp 1", redirect_pend); else pass_cnt++;
        exc_req = 1'b1; eret_req = 1'b1; epc_in = 32'h00003024;
        step();
        exc_req = 1'b0; eret_req = 1'b0;
        total_cnt++; if (pc !== 32'h00004180) $display("FAIL exc_pc got %h exp %h", pc, 32'h00004180); else pass_cnt++;
        total_cnt++; if (redirect_pend !== 1'b0) $display("FAIL exc_pend got %b exp 0", redirect_pend); else pass_cnt++;
        step();
        total_cnt++; if (pc !== 32'h00004180) $display("FAIL exc_stall_hold got %h exp %h", pc, 32'h00004180); else pass_cnt++;
        eret_req = 1'b1; epc_in = 32'h00003024;
        step();
        eret_req = 1'b0;
        total_cnt++; if (pc !== 32'h00003024) $display("FAIL eret_pc got %h exp %h", pc, 32'h00003024); else pass_cnt++;
    endtask

    task automatic test_wrap_misalign();
        en = 1'b1; jmp_take = 1'b1; jmp_target = 32'hFFFFFFFC;
        step();
        jmp_take = 1'b0;
        total_cnt++; if (pc !== 32'hFFFFFFFC) $display("FAIL wrap_load got %h exp %h", pc, 32'hFFFFFFFC); else pass_cnt++;
        total_cnt++; if (pc_plus !== 32'h00000000) $display("FAIL wrap_plus got %h exp %h", pc_plus, 32'h00000000); else pass_cnt++;
        step();
        total_cnt++; if (pc !== 32'h00000000) $display("FAIL wrap_pc got %h exp %h", pc, 32'h00000000); else pass_cnt++;
        jmp_take = 1'b1; jmp_target = 32'h00003002;
        step();
        jmp_take = 1'b0;
        total_cnt++; if (pc !== 32'h00003002) $display("FAIL misal_pc got %h exp %h", pc, 32'h00003002); else pass_cnt++;
        total_cnt++; if (misalign !== 1'b1) $display("FAIL misal_flag got %b exp 1", misalign); else pass_cnt++;
        total_cnt++; if (pc_plus !== 32'h00003006) $display("FAIL misal_plus got %h exp %h", pc_plus, 32'h00003006); else pass_cnt++;
    endtask

    task automatic test_reset_mid_stall();
        en = 1'b0; jmp_take = 1'b1; jmp_target = 32'h00003500;
        step();
        jmp_take = 1'b0;
        total_cnt++; if (redirect_pend !== 1'b1) $display("FAIL rst_stall_pre got %b exp 1", redirect_pend); else pass_cnt++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        total_cnt++; if (pc !== 32'h00003000) $display("FAIL rst_stall_pc got %h exp %h", pc, 32'h00003000); else pass_cnt++;
        total_cnt++; if (redirect_pend !== 1'b0) $display("FAIL rst_stall_pend got %b exp 0", redirect_pend); else pass_cnt++;
        total_cnt++; if (misalign !== 1'b0) $display("FAIL rst_stall_misal got %b exp 0", misalign); else pass_cnt++;
        en = 1'b1;
        step();
        total_cnt++; if (pc !== 32'h00003004) $display("FAIL rst_stall_next got %h exp %h", pc, 32'h00003004); else pass_cnt++;
    endtask

    // Test sequence.
    initial begin
        pass_cnt   = 0;
        total_cnt  = 0;
        reset      = 1'b1;
        en         = 1'b0;
        br_take    = 1'b0;
        br_target  = 32'h0;
        jmp_take   = 1'b0;
        jmp_target = 32'h0;
        exc_req    = 1'b0;
        eret_req   = 1'b0;
        epc_in     = 32'h0;
        step();
        test_reset();
        test_sequential();
        test_buffered_branch();
        test_pending_priority();
        test_exc_eret();
        test_wrap_misalign();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the pipelined CPU's IF stage; successor to the plain PC register.
- Holds the fetch PC and performs next-PC selection: sequential increment, branch, jump/jr redirect, exception entry and eret return.
- Buffers a redirect that arrives while IF is stalled, so control transfers are never lost across stall cycles.
- Flags misaligned fetch addresses for the exception logic.

Parameters:
WIDTH, 32, PC and target width in bits
RESET_VEC, 32'h00003000, PC value after reset
EXC_VEC, 32'h00004180, exception handler entry address
INC, 4, sequential increment in bytes

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
en  in  1  IF advance enable; 0 = stall
br_take  in  1  branch resolved taken (from ID)
br_target  in  WIDTH  branch target
jmp_take  in  1  j/jal/jr/jalr redirect (from ID)
jmp_target  in  WIDTH  jump target
exc_req  in  1  exception/interrupt entry request
eret_req  in  1  eret return request
epc_in  in  WIDTH  return address for eret
pc  out  WIDTH  current fetch PC (registered)
pc_plus  out  WIDTH  pc + INC (combinational)
redirect_pend  out  1  a buffered redirect is waiting
misalign  out  1  pc[1:0] != 0 (combinational)

Behaviour:
- Reset (sync, highest priority): pc <= RESET_VEC; pending buffer cleared. redirect_pend = 0. misalign = 0 if RESET_VEC is word-aligned.
- State: pc register; pending register {pend_valid, pend_kind (JMP/BR), pend_target}.
- Per-cycle priority when not in reset:
  1. exc_req=1: pc <= EXC_VEC regardless of en; pending cleared.
  2. else eret_req=1: pc <= epc_in regardless of en; pending cleared.
  3. else en=1 and pend_valid: pc <= pend_target; pending cleared. Fresh br_take/jmp_take this cycle are ignored, because the stalled instruction already issued its redirect.
  4. else en=1, jmp_take: pc <= jmp_target.
  5. else en=1, br_take: pc <= br_target.
  6. else en=1: pc <= pc + INC.
  7. else (en=0): pc holds.
- Capture while stalled (en=0, no exc/eret):
  - jmp_take or br_take loads the pending buffer with the selected target (jmp over br).
  - If pending already holds a valid entry, a new request overwrites it only if it is strictly higher priority (JMP over BR). Same or lower priority keeps the buffered entry.
- Timing:
  - Redirect with en=1 takes effect one cycle later: pc shows the target after the next rising edge.
  - Buffered redirect appears on pc at the first edge with en=1.
- Arithmetic: pc + INC is modulo 2^WIDTH; 32'hFFFFFFFC + 4 wraps to 0 with no error flag.
- Targets are not aligned or masked. A misaligned target is loaded as-is and raises misalign.
- exc_req and eret_req both high: exc wins.
- Reset asserted mid-stall with pending valid: pending is discarded and pc = RESET_VEC.
- redirect_pend mirrors pend_valid (registered).

Test Plan:
- Reset then en=1 for 3 cycles -> pc = 0x3000, 0x3004, 0x3008, 0x300C; redirect_pend=0; misalign=0.
- pc=0x3010, en=0 with br_take=1, br_target=0x3040 for one cycle, then en=0 with br low for 2 cycles, then en=1 -> redirect_pend=1 during stall, pc holds 0x3010; after the en=1 edge pc=0x3040, redirect_pend=0.
- Stalled with BR pending to 0x3040, then jmp_take=1, jmp_target=0x3100 while en=0, then en=1 -> pc=0x3100. Repeat with the order reversed (JMP first, BR second) -> pc=0x3100.
- en=0, exc_req=1 and eret_req=1 simultaneously, BR pending -> next pc=0x4180 (EXC_VEC), redirect_pend=0. Later eret_req=1, epc_in=0x3024 -> pc=0x3024.
- pc forced to 0xFFFFFFFC via jmp, then en=1 -> pc=0x00000000. jmp_target=0x3002 -> misalign=1 on the following cycle.
- reset=1 while en=0 with pending valid -> pc=0x3000, redirect_pend=0. With en=1 afterwards, pc=0x3004 (pending not applied).
